// File: rtl/bp_pkg.sv
// Shared types, constants and helpers for the branch predictor table.
package bp_pkg;

    // Widest counter the table supports; narrower counters use the low bits.
    localparam int unsigned CTR_W_MAX = 4;

    // Counter reset value: all-ones, i.e. strongly taken at any width.
    localparam logic [CTR_W_MAX-1:0] CTR_RESET = '1;

    // Table size at the default index width.
    localparam int unsigned DEF_INDEX_W = 6;
    localparam int unsigned ENTRIES     = 1 << DEF_INDEX_W;

    // Saturating up/down step for a counter that is 'width' bits wide.
    function automatic logic [CTR_W_MAX-1:0] sat_next(
        input logic [CTR_W_MAX-1:0] ctr,
        input logic                 dir,
        input int unsigned          width
    );
        logic [CTR_W_MAX-1:0] max_val;
        max_val = CTR_W_MAX'((32'd1 << width) - 32'd1);
        if (dir) begin
            return (ctr >= max_val) ? max_val : ctr + CTR_W_MAX'(1);
        end
        return (ctr == '0) ? '0 : ctr - CTR_W_MAX'(1);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One table entry: CTR_W-bit saturating counter, reset to strongly taken.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int unsigned CTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic             dir,
    output logic [CTR_W-1:0] value
);

    // Reset to all-ones, otherwise step toward the resolved direction when enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value <= CTR_W'(CTR_RESET);
        end else if (en) begin
            value <= CTR_W'(sat_next(CTR_W_MAX'(value), dir, CTR_W));
        end
    end

endmodule

// File: rtl/branch_predictor_table.sv
// Table of saturating counters with optional gshare hashing and perf counters.
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned INDEX_W   = 6,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned HIST_W    = 4,
    parameter int unsigned GSHARE_EN = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               predict_o,
    output logic [INDEX_W-1:0] predict_idx_o,
    input  logic               update_i,
    input  logic [INDEX_W-1:0] update_idx_i,
    input  logic               result_i,
    input  logic               mispredict_i,
    output logic [HIST_W-1:0]  ghr_o,
    output logic [CNT_W-1:0]   branch_cnt_o,
    output logic [CNT_W-1:0]   mispredict_cnt_o
);

    localparam int unsigned TABLE_SIZE = 1 << INDEX_W;

    logic [CTR_W-1:0]   ctr_q [TABLE_SIZE];
    logic [HIST_W-1:0]  ghr_q;
    logic [INDEX_W-1:0] raw_idx;
    logic               unused_pc;

    // PC bits outside the index field (word offset and high bits) play no part.
    assign unused_pc = ^{pc_i[PC_W-1:INDEX_W+2], pc_i[1:0]};

    // Zero-latency lookup; no bypass from a same-cycle update.
    always_comb begin
        raw_idx = pc_i[INDEX_W+1:2];
        if (GSHARE_EN != 0) begin
            predict_idx_o = raw_idx ^ INDEX_W'(ghr_q);
        end else begin
            predict_idx_o = raw_idx;
        end
        predict_o = ctr_q[predict_idx_o][CTR_W-1];
    end

    // One counter per entry; only the entry named by the resolving branch moves.
    for (genvar i = 0; i < TABLE_SIZE; i++) begin : g_entry
        bp_sat_ctr #(
            .CTR_W(CTR_W)
        ) u_ctr (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .en   (update_i && (update_idx_i == INDEX_W'(i))),
            .dir  (result_i),
            .value(ctr_q[i])
        );
    end

    // Non-speculative history and saturating perf counters, advanced on resolve.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q            <= '0;
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else if (update_i) begin
            if (GSHARE_EN != 0) begin
                ghr_q <= HIST_W'({ghr_q, result_i});
            end
            if (branch_cnt_o != '1) begin
                branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            end
            if (mispredict_i && (mispredict_cnt_o != '1)) begin
                mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
            end
        end
    end

    assign ghr_o = ghr_q;

endmodule
